// File: rtl/vector_exec_pipe.sv
// Multi-lane SIMD execution pipeline: per-lane ALU in stage 0, then a
// STAGES-deep shift of result/we/rd that stalls as a whole on back-pressure.

module vector_exec_lane #(
  parameter int ELEM_W = 32
) (
  input  logic [2:0]        op,
  input  logic              sat,
  input  logic [ELEM_W-1:0] a,
  input  logic [ELEM_W-1:0] b,
  output logic [ELEM_W-1:0] y
);
  localparam int SH_W = $clog2(ELEM_W);

  logic [ELEM_W:0]   sum;
  logic [ELEM_W:0]   dif;
  logic [ELEM_W-1:0] prod;
  logic [SH_W-1:0]   sh;

  // Top bit of sum is the carry, top bit of dif is the borrow.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign dif  = {1'b0, a} - {1'b0, b};
  assign prod = a * b;
  assign sh   = b[SH_W-1:0];

  always_comb begin
    y = '0;
    case (op)
      3'b000: y = (sat && sum[ELEM_W]) ? '1 : sum[ELEM_W-1:0];
      3'b001: y = (sat && dif[ELEM_W]) ? '0 : dif[ELEM_W-1:0];
      3'b010: y = a & b;
      3'b011: y = a | b;
      3'b100: y = a ^ b;
      3'b101: y = prod;
      3'b110: y = a << sh;
      3'b111: y = a >> sh;
      default: y = '0;
    endcase
  end
endmodule

module vector_exec_pipe #(
  parameter int LANES  = 4,
  parameter int ELEM_W = 32,
  parameter int STAGES = 3,
  parameter int REGS   = 16,
  parameter int RW     = $clog2(REGS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              in_op,
  input  logic                    in_sat,
  input  logic                    in_we,
  input  logic [RW-1:0]           in_rd,
  input  logic [LANES*ELEM_W-1:0] in_a,
  input  logic [LANES*ELEM_W-1:0] in_b,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*ELEM_W-1:0] out_result,
  output logic                    out_we,
  output logic [RW-1:0]           out_rd,
  output logic [REGS-1:0]         pend_mask
);
  localparam int V = LANES * ELEM_W;

  typedef struct packed {
    logic [V-1:0]  res;
    logic          we;
    logic [RW-1:0] rd;
  } stage_t;

  logic [LANES-1:0][ELEM_W-1:0] a_l, b_l, y_l;
  stage_t                       st [STAGES];
  logic [STAGES-1:0]            vld_pipe;
  logic                         adv, fire;

  assign a_l = in_a;
  assign b_l = in_b;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    vector_exec_lane #(.ELEM_W(ELEM_W)) u_lane (
      .op  (in_op),
      .sat (in_sat),
      .a   (a_l[i]),
      .b   (b_l[i]),
      .y   (y_l[i])
    );
  end

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && !flush;
  assign fire     = in_valid && in_ready;

  // Data shifts on every advance; only the valid bits decide what is live.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      for (int i = 0; i < STAGES; i++) st[i] <= '0;
    end else begin
      if (adv) begin
        st[0]       <= '{res: y_l, we: in_we, rd: in_rd};
        vld_pipe[0] <= fire;
        for (int i = 1; i < STAGES; i++) begin
          st[i]       <= st[i-1];
          vld_pipe[i] <= vld_pipe[i-1];
        end
      end
      if (flush) vld_pipe <= '0;
    end
  end

  assign out_valid  = vld_pipe[STAGES-1];
  assign out_result = st[STAGES-1].res;
  assign out_we     = st[STAGES-1].we;
  assign out_rd     = st[STAGES-1].rd;

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < STAGES; i++)
      if (vld_pipe[i] && st[i].we) pend_mask[st[i].rd] = 1'b1;
  end
endmodule

// File: doc/vector_exec_pipe.md
# vector_exec_pipe

Parametrised multi-lane SIMD execution pipeline for the vector processor datapath. It replaces the single-cycle ALU slot between the decode/execute register and the memory stage. It accepts one vector operation per cycle over a valid/ready handshake and carries it through a configurable number of pipeline stages. It supports per-lane saturating arithmetic, back-pressure, and flush, and it exports a pending-destination mask so the hazard logic can stall or forward on in-flight results.

## Interface
Parameters:
- LANES, 4, number of independent SIMD lanes
- ELEM_W, 32, lane element width in bits (power of two, ≥8)
- STAGES, 3, pipeline depth in cycles (≥1)
- REGS, 16, number of architectural vector registers
- RW, $clog2(REGS), destination tag width
- Derived (localparam, not overridable): V = LANES*ELEM_W

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset; one clock, reset sampled on rising edge of clk
- in_valid  in  1  operation presented
- in_ready  out  1  pipeline can accept this cycle
- in_op  in  3  operation code
- in_sat  in  1  saturating mode for add/sub
- in_we  in  1  operation writes a register
- in_rd  in  RW  destination register tag
- in_a  in  V  operand A, lane i = bits [i*ELEM_W +: ELEM_W]
- in_b  in  V  operand B, same lane packing
- flush  in  1  discard all in-flight operations
- out_valid  out  1  result available at last stage
- out_ready  in  1  downstream accepts result
- out_result  out  V  lane results
- out_we  out  1  write enable carried with result
- out_rd  out  RW  destination tag carried with result
- pend_mask  out  REGS  bit r = 1 when any valid stage holds in_we=1, rd=r

## Operation
- Op codes, applied per lane with no carry or borrow between lanes:
  - 000 add, 001 sub, 010 and, 011 or, 100 xor
  - 101 mul: low ELEM_W bits of the unsigned product
  - 110 sll, 111 srl: shift amount = low log2(ELEM_W) bits of the lane's B element
- in_sat=1 affects only add and sub, both unsigned:
  - add overflow clamps to all-ones
  - sub underflow clamps to 0
  - in_sat is ignored for all other ops.
- Computation happens in stage 0. Stages 1..STAGES-1 carry the result, we, rd and a valid bit. The last stage drives the out_* ports.
- Accept: an input transfer occurs when in_valid && in_ready.
- Advance:
  - The whole pipeline advances when adv = !out_valid || out_ready. There is no per-stage bubble collapse.
  - When adv=0, every stage holds its contents.
- in_ready = adv && !flush.
- Output transfer occurs when out_valid && out_ready. If no new op is accepted, the slot behind it becomes a bubble.
- Flush:
  - Clears every stage valid bit at the next edge.
  - An input offered in the same cycle is dropped (in_ready=0).
  - An output completing in the same cycle is still consumed by downstream; the core treats it as discarded.
- pend_mask is combinational from the stage valid, we and rd bits. Entries with we=0 never set bits, and duplicate tags OR together.
- Reset:
  - Clears all valid bits.
  - Sets out_result=0, out_we=0, out_rd=0, out_valid=0 and pend_mask=0.
  - Reset mid-operation discards all in-flight ops, and rst takes priority over flush.

## Timing
- Latency is exactly STAGES cycles from the accept edge to out_valid, provided the output is not stalled.
- Throughput is 1 op/cycle while out_ready=1.
- in_ready is combinational from out_valid, out_ready and flush. There is no combinational path from in_valid to in_ready.
- out_result, out_we, out_rd and out_valid are registered.
- out_result, out_we and out_rd are stable while out_valid=1 && out_ready=0.
- When the pipeline is full and stalled, in_ready=0 until the cycle out_ready rises. In that cycle, accept and output transfer happen simultaneously.
- pend_mask reflects the accepted op in the cycle after the accept. It clears in the cycle after the op's output transfer or a flush.
- With STAGES=1, out_valid rises the cycle after accept, and the same handshake rules apply.

## Test plan
Default parameters (LANES=4, ELEM_W=32, STAGES=3).

1. Basic add:
   - Stimulus: cycle 0 accept add, A lanes {4,3,2,1}, B {1,1,1,1}, rd=5, we=1, out_ready=1.
   - Required: out_valid only in cycle 3 with {5,4,3,2}, out_rd=5; pend_mask=0x0020 in cycles 1–3, 0 in cycle 4.
2. Saturation:
   - Add with lane A=0xFFFFFFF0, B=0x20: sat=1 gives 0xFFFFFFFF; sat=0 gives 0x00000010.
   - Sub 1−2: sat=1 gives 0; sat=0 gives 0xFFFFFFFF.
   - Neighbouring lanes are unaffected.
3. Shift and mul:
   - sll with lane A=1, B=33 gives 2 (amount 1).
   - srl with A=0x80000000, B=31 gives 1.
   - mul with 0x10000 × 0x10000 gives 0.
   - mul with 3 × 5 gives 15.
4. Back-pressure:
   - Stimulus: stream 6 ops, rd 1–6, hold out_ready=0 in cycles 3–7.
   - Required: in_ready=0 once 3 ops are held; outputs stable while stalled; all 6 results emerge in order with none lost or duplicated.
5. Flush:
   - Stimulus: accept ops in cycles 0 and 1, assert flush in cycle 2 with in_valid=1.
   - Required: in_ready=0 in cycle 2; out_valid stays 0; pend_mask=0 from cycle 3; the next op accepted in cycle 3 emerges in cycle 6.
6. Reset mid-flight:
   - Stimulus: assert rst in cycle 2 with 2 ops in flight and out_ready=0.
   - Required: all outputs 0 in cycle 3; no stale result emerges afterward.
